// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// datapath mux selects, ALU control codes, FSM states and instruction classes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [1:0] ALU_ADDU = 2'b00;
  localparam logic [1:0] ALU_SUBU = 2'b01;
  localparam logic [1:0] ALU_ORI  = 2'b10;
  localparam logic [1:0] ALU_LUI  = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRC_B_RT      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_RTYPE_WB, S_EXEC_I, S_ITYPE_WB, S_BRANCH, S_JUMP
  } state_t;

  typedef enum logic [2:0] {
    CLS_MEM_LD, CLS_MEM_ST, CLS_RTYPE, CLS_ITYPE, CLS_BRANCH, CLS_JUMP, CLS_ILLEGAL
  } instr_class_t;

endpackage

// File: rtl/mips_multicycle_ctrl_instr_class_dec.sv
// Combinational instruction classifier: op/funct to instruction class plus
// the ALU control code used in the execute state.
module instr_class_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   funct,
  output instr_class_t cls,
  output logic [1:0]   alu_ctl,
  output logic         is_add
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    cls     = CLS_ILLEGAL;
    alu_ctl = ALU_ADDU;
    is_add  = 1'b0;
    case (op)
      OP_LW:  cls = CLS_MEM_LD;
      OP_SW:  cls = CLS_MEM_ST;
      OP_BEQ: cls = CLS_BRANCH;
      OP_J:   cls = CLS_JUMP;
      OP_ORI: begin
        cls     = CLS_ITYPE;
        alu_ctl = ALU_ORI;
      end
      OP_LUI: begin
        cls     = CLS_ITYPE;
        alu_ctl = ALU_LUI;
      end
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls = CLS_RTYPE;
          FN_SUBU: begin
            cls     = CLS_RTYPE;
            alu_ctl = ALU_SUBU;
          end
          FN_ADD: begin
            cls    = CLS_RTYPE;
            is_add = 1'b1;
          end
          default: cls = CLS_ILLEGAL;
        endcase
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM driving the PC/regfile/ALU/memory datapath.
// Optional OVERFLOW_TRAP_EN: signed add overflow suppresses writeback and pulses ovf_trap.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                overflow,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                ir_we,
  output logic                mdr_we,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic                iord,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                ext_op,
  output logic [1:0]          alu_ctl,
  output logic                reg_we,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                illegal,
  output logic                ovf_trap,
  output logic [RETIRE_W-1:0] retired
);

  state_t       state, state_next;
  instr_class_t dec_cls;
  logic [1:0]   dec_alu_ctl;
  logic         dec_is_add;
  logic         retire_inc;

  instr_class_dec u_dec (
    .op      (op),
    .funct   (funct),
    .cls     (dec_cls),
    .alu_ctl (dec_alu_ctl),
    .is_add  (dec_is_add)
  );

`ifndef OVERFLOW_TRAP_EN
  logic unused_ovf;
  assign unused_ovf = overflow ^ dec_is_add;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      state <= state_next;
      if (retire_inc) retired <= retired + RETIRE_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    mdr_we     = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_SRC_ALU;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_RT;
    ext_op     = 1'b0;
    alu_ctl    = ALU_ADDU;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    ovf_trap   = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRC_B_IMM_SH2;
        ext_op    = 1'b1;
        case (dec_cls)
          CLS_MEM_LD, CLS_MEM_ST: state_next = S_MEM_ADDR;
          CLS_RTYPE:              state_next = S_EXEC_R;
          CLS_ITYPE:              state_next = S_EXEC_I;
          CLS_BRANCH:             state_next = S_BRANCH;
          CLS_JUMP:               state_next = S_JUMP;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        ext_op     = 1'b1;
        state_next = (dec_cls == CLS_MEM_ST) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          mdr_we     = 1'b1;
          state_next = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_ctl    = dec_alu_ctl;
        state_next = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        reg_we     = 1'b1;
        reg_dst    = 1'b1;
        state_next = S_FETCH;
`ifdef OVERFLOW_TRAP_EN
        // Re-present the execute operands so overflow is live for the add check.
        alu_src_a = 1'b1;
        if (dec_is_add && overflow) begin
          reg_we   = 1'b0;
          ovf_trap = 1'b1;
        end
`endif
      end
      S_EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        alu_ctl    = dec_alu_ctl;
        state_next = S_ITYPE_WB;
      end
      S_ITYPE_WB: begin
        reg_we     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctl    = ALU_SUBU;
        pc_we      = zero;
        pc_src     = PC_SRC_ALUOUT;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_we      = 1'b1;
        pc_src     = PC_SRC_JUMP;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    retire_inc = (state != S_FETCH) && (state_next == S_FETCH) && !illegal && !ovf_trap;

    // Hold every control output quiet while reset is asserted.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      mdr_we     = 1'b0;
      pc_we      = 1'b0;
      pc_src     = PC_SRC_ALU;
      iord       = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRC_B_RT;
      ext_op     = 1'b0;
      alu_ctl    = ALU_ADDU;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      ovf_trap   = 1'b0;
      retire_inc = 1'b0;
    end
  end

endmodule
